// File: rtl/cmp_pkg.sv
// Shared definitions for the comparator-sharing controller: function codes,
// result codes and the controller state encoding.
package cmp_pkg;

    localparam logic [1:0] FUN_NOP = 2'd0;
    localparam logic [1:0] FUN_EQ  = 2'd1;
    localparam logic [1:0] FUN_GT  = 2'd2;
    localparam logic [1:0] FUN_LT  = 2'd3;

    localparam logic [1:0] RES_NONE = 2'd0;
    localparam logic [1:0] RES_EQ   = 2'd1;
    localparam logic [1:0] RES_GT   = 2'd2;
    localparam logic [1:0] RES_LT   = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Reference meaning of each function code, given the signed relation of A to B.
    function automatic logic [1:0] cmp_result(input logic [1:0] fun, input logic eq,
                                              input logic gt, input logic lt);
        logic [1:0] res;
        res = RES_NONE;
        case (fun)
            FUN_EQ:  res = eq ? RES_EQ : RES_NONE;
            FUN_GT:  res = gt ? RES_GT : RES_NONE;
            FUN_LT:  res = lt ? RES_LT : RES_NONE;
            default: res = RES_NONE;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester after the last-grant
// pointer wins, searching upward with wrap-around.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx
);

    logic [IDW-1:0] cand;
    logic           found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = ptr;
        for (int i = 0; i < NREQ; i++) begin
            if (cand == IDW'(NREQ - 1)) begin
                cand = '0;
            end else begin
                cand = cand + 1'b1;
            end
            if (!found && req[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
        if (en && found) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/cmp_share_ctrl.sv
// Shares one registered signed comparator among NREQ requesters: arbitrate,
// issue a one-cycle enable, wait for the flag (with watchdog), return the result.
module cmp_share_ctrl
    import cmp_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = 16,
    parameter int IDW  = 2,
    parameter int TMO  = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [NREQ-1:0]  REQ_VALID,
    output logic [NREQ-1:0]  REQ_READY,
    input  logic [NREQ*DW-1:0] REQ_A,
    input  logic [NREQ*DW-1:0] REQ_B,
    input  logic [NREQ*2-1:0]  REQ_FUN,
    output logic [DW-1:0]    CMP_A,
    output logic [DW-1:0]    CMP_B,
    output logic [1:0]       CMP_FUN,
    output logic             CMP_EN,
    input  logic [1:0]       CMP_OUT,
    input  logic             CMP_FLAG,
    output logic             RSP_VALID,
    input  logic             RSP_READY,
    output logic [IDW-1:0]   RSP_ID,
    output logic [1:0]       RSP_OUT,
    output logic             RSP_ERR
);

    localparam int CW = $clog2(TMO);

    state_t          state;
    state_t          nstate;
    logic [IDW-1:0]  ptr;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  gidx;
    logic            arb_en;
    logic [DW-1:0]   op_a;
    logic [DW-1:0]   op_b;
    logic [1:0]      op_fun;
    logic [IDW-1:0]  op_id;
    logic [CW-1:0]   wd_cnt;
    logic            wd_expired;
    logic            rsp_valid_q;
    logic [IDW-1:0]  rsp_id_q;
    logic [1:0]      rsp_out_q;
    logic            rsp_err_q;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req       (REQ_VALID),
        .ptr       (ptr),
        .en        (arb_en),
        .grant     (grant),
        .grant_idx (gidx)
    );

    assign wd_expired = (wd_cnt == CW'(TMO - 1));
    assign REQ_READY  = grant;
    assign CMP_A      = op_a;
    assign CMP_B      = op_b;
    assign CMP_FUN    = op_fun;
    assign RSP_VALID  = rsp_valid_q;
    assign RSP_ID     = rsp_id_q;
    assign RSP_OUT    = rsp_out_q;
    assign RSP_ERR    = rsp_err_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= nstate;
        end
    end

    // Arbitration is gated by RST so no grant can leak out while reset is held.
    always_comb begin
        nstate = state;
        arb_en = 1'b0;
        CMP_EN = 1'b0;
        case (state)
            IDLE: begin
                arb_en = RST;
                if (|grant) begin
                    nstate = ISSUE;
                end
            end
            ISSUE: begin
                CMP_EN = 1'b1;
                nstate = WAIT;
            end
            WAIT: begin
                if (CMP_FLAG || wd_expired) begin
                    nstate = RESP;
                end
            end
            RESP: begin
                if (RSP_READY) begin
                    nstate = IDLE;
                end
            end
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ptr         <= IDW'(NREQ - 1);
            op_a        <= '0;
            op_b        <= '0;
            op_fun      <= FUN_NOP;
            op_id       <= '0;
            wd_cnt      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_out_q   <= RES_NONE;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|grant) begin
                        op_a   <= REQ_A[int'(gidx)*DW +: DW];
                        op_b   <= REQ_B[int'(gidx)*DW +: DW];
                        op_fun <= REQ_FUN[int'(gidx)*2 +: 2];
                        op_id  <= gidx;
                        ptr    <= gidx;
                    end
                end
                ISSUE: begin
                    wd_cnt <= '0;
                end
                // A flag arriving on the watchdog's last cycle still wins.
                WAIT: begin
                    if (CMP_FLAG) begin
                        rsp_out_q   <= CMP_OUT;
                        rsp_err_q   <= 1'b0;
                        rsp_id_q    <= op_id;
                        rsp_valid_q <= 1'b1;
                    end else if (wd_expired) begin
                        rsp_out_q   <= RES_NONE;
                        rsp_err_q   <= 1'b1;
                        rsp_id_q    <= op_id;
                        rsp_valid_q <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (RSP_READY) begin
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_share_ctrl.sv
// Scoreboard bench for cmp_share_ctrl with a behavioural registered comparator
// beside it; expected responses are queued at issue and checked on handshake.
module tb_cmp_share_ctrl;

    localparam int NREQ = 4;
    localparam int DW   = 16;
    localparam int IDW  = 2;
    localparam int TMO  = 8;

    logic               CLK = 1'b0;
    logic               RST = 1'b0;
    logic [NREQ-1:0]    REQ_VALID;
    logic [NREQ-1:0]    REQ_READY;
    logic [NREQ*DW-1:0] REQ_A;
    logic [NREQ*DW-1:0] REQ_B;
    logic [NREQ*2-1:0]  REQ_FUN;
    logic [DW-1:0]      CMP_A;
    logic [DW-1:0]      CMP_B;
    logic [1:0]         CMP_FUN;
    logic               CMP_EN;
    logic [1:0]         CMP_OUT;
    logic               CMP_FLAG;
    logic               RSP_VALID;
    logic               RSP_READY;
    logic [IDW-1:0]     RSP_ID;
    logic [1:0]         RSP_OUT;
    logic               RSP_ERR;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    logic flag_en = 1'b1;
    logic prev_en = 1'b0;

    typedef struct packed {
        logic [1:0] id;
        logic [1:0] res;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   grant_id_q[$];
    int   grant_cyc_q[$];
    int   mon_gi;

    cmp_share_ctrl #(
        .NREQ (NREQ),
        .DW   (DW),
        .IDW  (IDW),
        .TMO  (TMO)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ_VALID (REQ_VALID),
        .REQ_READY (REQ_READY),
        .REQ_A     (REQ_A),
        .REQ_B     (REQ_B),
        .REQ_FUN   (REQ_FUN),
        .CMP_A     (CMP_A),
        .CMP_B     (CMP_B),
        .CMP_FUN   (CMP_FUN),
        .CMP_EN    (CMP_EN),
        .CMP_OUT   (CMP_OUT),
        .CMP_FLAG  (CMP_FLAG),
        .RSP_VALID (RSP_VALID),
        .RSP_READY (RSP_READY),
        .RSP_ID    (RSP_ID),
        .RSP_OUT   (RSP_OUT),
        .RSP_ERR   (RSP_ERR)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [1:0] cmpModel(input logic [1:0] fun, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
        logic [1:0] r;
        r = 2'd0;
        case (fun)
            2'd1: r = ($signed(a) == $signed(b)) ? 2'd1 : 2'd0;
            2'd2: r = ($signed(a) >  $signed(b)) ? 2'd2 : 2'd0;
            2'd3: r = ($signed(a) <  $signed(b)) ? 2'd3 : 2'd0;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    // Registered comparator; flag_en lets the bench suppress the flag to hit the watchdog.
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            CMP_FLAG <= 1'b0;
            CMP_OUT  <= 2'd0;
        end else begin
            CMP_FLAG <= CMP_EN && flag_en;
            CMP_OUT  <= CMP_EN ? cmpModel(CMP_FUN, CMP_A, CMP_B) : 2'd0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic pushExp(input logic [1:0] id, input logic [1:0] res, input logic err);
        exp_t e;
        e.id  = id;
        e.res = res;
        e.err = err;
        exp_q.push_back(e);
    endtask

    always @(negedge CLK) begin
        if (RST && RSP_VALID && RSP_READY) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_rsp: got id %0d out %0d, expected no response",
                         RSP_ID, RSP_OUT);
            end else begin
                mon_e = exp_q.pop_front();
                if (!mon_e.err) checkOutput("rsp_id", 32'(RSP_ID), 32'(mon_e.id));
                checkOutput("rsp_out", 32'(RSP_OUT), 32'(mon_e.res));
                checkOutput("rsp_err", 32'(RSP_ERR), 32'(mon_e.err));
            end
        end
    end

    always @(negedge CLK) begin
        if (RST && REQ_READY != '0) begin
            checkOutput("ready_onehot", 32'($onehot(REQ_READY)), 32'd1);
            mon_gi = 0;
            for (int i = 0; i < NREQ; i++) if (REQ_READY[i]) mon_gi = i;
            grant_id_q.push_back(mon_gi);
            grant_cyc_q.push_back(cyc);
        end
        if (RST && CMP_EN) checkOutput("cmp_en_single", 32'(prev_en), 32'd0);
        prev_en <= RST & CMP_EN;
    end

    task automatic applyStimulus(input int id, input logic [1:0] fun, input logic [DW-1:0] a,
                                 input logic [DW-1:0] b, output int gcyc);
        @(posedge CLK);
        #1;
        REQ_A[id*DW +: DW] = a;
        REQ_B[id*DW +: DW] = b;
        REQ_FUN[id*2 +: 2] = fun;
        REQ_VALID[id]      = 1'b1;
        gcyc = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge CLK);
            if (REQ_READY[id]) begin
                gcyc = cyc;
                break;
            end
        end
        if (gcyc < 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL grant_wait: got no grant, expected REQ_READY[%0d]", id);
        end
        @(posedge CLK);
        #1;
        REQ_VALID[id] = 1'b0;
    endtask

    task automatic waitRspValid(output int vcyc);
        vcyc = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge CLK);
            if (RSP_VALID) begin
                vcyc = cyc;
                break;
            end
        end
        if (vcyc < 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL rsp_wait: got no RSP_VALID, expected one");
        end
    endtask

    task automatic waitDrain(input string name);
        for (int k = 0; k < 200; k++) begin
            if (exp_q.size() == 0) break;
            @(negedge CLK);
        end
        checkOutput(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        int g, v, rc, gc, n0;
        REQ_VALID = '0;
        REQ_A     = '0;
        REQ_B     = '0;
        REQ_FUN   = '0;
        RSP_READY = 1'b1;

        // Reset: requests present but nothing may be granted
        REQ_VALID = '1;
        repeat (2) @(negedge CLK);
        checkOutput("rst_req_ready", 32'(REQ_READY), 32'd0);
        checkOutput("rst_cmp_en",    32'(CMP_EN),    32'd0);
        checkOutput("rst_cmp_a",     32'(CMP_A),     32'd0);
        checkOutput("rst_cmp_b",     32'(CMP_B),     32'd0);
        checkOutput("rst_cmp_fun",   32'(CMP_FUN),   32'd0);
        checkOutput("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
        checkOutput("rst_rsp_out",   32'(RSP_OUT),   32'd0);
        checkOutput("rst_rsp_err",   32'(RSP_ERR),   32'd0);
        checkOutput("rst_rsp_id",    32'(RSP_ID),    32'd0);
        REQ_VALID = '0;
        @(posedge CLK);
        #1;
        RST = 1'b1;

        // 1: single request, latency
        pushExp(2'd1, 2'd2, 1'b0);
        applyStimulus(1, 2'd2, 16'd5, 16'hFFFD, g);
        @(negedge CLK);
        checkOutput("t1_cmp_en_c1", 32'(CMP_EN),  32'd1);
        checkOutput("t1_cmp_a",     32'(CMP_A),   32'd5);
        checkOutput("t1_cmp_b",     32'(CMP_B),   32'hFFFD);
        checkOutput("t1_cmp_fun",   32'(CMP_FUN), 32'd2);
        @(negedge CLK);
        checkOutput("t1_cmp_en_c2",    32'(CMP_EN),    32'd0);
        checkOutput("t1_rsp_valid_c2", 32'(RSP_VALID), 32'd0);
        checkOutput("t1_cmp_a_hold",   32'(CMP_A),     32'd5);
        waitRspValid(v);
        checkOutput("t1_rsp_latency", 32'(v - g), 32'd3);
        waitDrain("t1_drain");

        // 2: signed LT, EQ on most-negative value, NOP
        pushExp(2'd3, 2'd3, 1'b0);
        applyStimulus(3, 2'd3, 16'hFFFF, 16'h0001, g);
        waitDrain("t2_lt_drain");
        pushExp(2'd3, 2'd1, 1'b0);
        applyStimulus(3, 2'd1, 16'h8000, 16'h8000, g);
        waitDrain("t2_eq_drain");
        pushExp(2'd3, 2'd0, 1'b0);
        applyStimulus(3, 2'd0, 16'h1234, 16'h1234, g);
        waitDrain("t2_nop_drain");

        // 3: fairness with all requesters held valid
        @(posedge CLK);
        #1;
        REQ_A   = {16'd9, 16'd7, 16'd1, 16'd3};
        REQ_B   = {16'd9, 16'd7, 16'd2, 16'd1};
        REQ_FUN = {2'd0, 2'd1, 2'd3, 2'd2};
        pushExp(2'd0, 2'd2, 1'b0);
        pushExp(2'd1, 2'd3, 1'b0);
        pushExp(2'd2, 2'd1, 1'b0);
        pushExp(2'd3, 2'd0, 1'b0);
        pushExp(2'd0, 2'd2, 1'b0);
        pushExp(2'd1, 2'd3, 1'b0);
        grant_id_q.delete();
        grant_cyc_q.delete();
        REQ_VALID = '1;
        for (int k = 0; k < 100; k++) begin
            @(negedge CLK);
            if (grant_id_q.size() >= 6) break;
        end
        @(posedge CLK);
        #1;
        REQ_VALID = '0;
        checkOutput("t3_grant_count", 32'(grant_id_q.size()), 32'd6);
        if (grant_id_q.size() == 6) begin
            for (int i = 0; i < 6; i++)
                checkOutput("t3_grant_order", 32'(grant_id_q[i]), 32'(i % 4));
            for (int i = 1; i < 6; i++)
                checkOutput("t3_grant_spacing", 32'(grant_cyc_q[i] - grant_cyc_q[i-1]), 32'd4);
        end
        waitDrain("t3_drain");

        // 4: response backpressure
        @(posedge CLK);
        #1;
        RSP_READY = 1'b0;
        pushExp(2'd2, 2'd2, 1'b0);
        pushExp(2'd0, 2'd3, 1'b0);
        applyStimulus(2, 2'd2, 16'hFFFE, 16'hFFFB, g);
        waitRspValid(v);
        @(posedge CLK);
        #1;
        REQ_A[0*DW +: DW] = 16'h8000;
        REQ_B[0*DW +: DW] = 16'h7FFF;
        REQ_FUN[0 +: 2]   = 2'd3;
        REQ_VALID[0]      = 1'b1;
        n0 = grant_id_q.size();
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            checkOutput("t4_stall_valid", 32'(RSP_VALID), 32'd1);
            checkOutput("t4_stall_id",    32'(RSP_ID),    32'd2);
            checkOutput("t4_stall_out",   32'(RSP_OUT),   32'd2);
            checkOutput("t4_stall_err",   32'(RSP_ERR),   32'd0);
            checkOutput("t4_stall_ready", 32'(REQ_READY), 32'd0);
            checkOutput("t4_stall_en",    32'(CMP_EN),    32'd0);
        end
        @(posedge CLK);
        #1;
        RSP_READY = 1'b1;
        rc = cyc;
        gc = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (grant_id_q.size() > n0) begin
                gc = grant_cyc_q[n0];
                break;
            end
        end
        checkOutput("t4_grant_delay", 32'(gc - rc), 32'd1);
        if (grant_id_q.size() > n0) checkOutput("t4_grant_id", 32'(grant_id_q[n0]), 32'd0);
        @(posedge CLK);
        #1;
        REQ_VALID[0] = 1'b0;
        waitDrain("t4_drain");

        // 5: watchdog timeout, then a normal operation
        @(posedge CLK);
        #1;
        flag_en = 1'b0;
        pushExp(2'd3, 2'd0, 1'b1);
        applyStimulus(3, 2'd2, 16'd10, 16'd1, g);
        waitRspValid(v);
        checkOutput("t5_timeout_latency", 32'(v - g), 32'd10);
        checkOutput("t5_err", 32'(RSP_ERR), 32'd1);
        waitDrain("t5_tmo_drain");
        flag_en = 1'b1;
        pushExp(2'd1, 2'd2, 1'b0);
        applyStimulus(1, 2'd2, 16'h7FFF, 16'h8000, g);
        waitDrain("t5_after_drain");

        // 6: reset while waiting for the flag
        applyStimulus(2, 2'd3, 16'd1, 16'd9, g);
        @(posedge CLK);
        #1;
        checkOutput("t6_pre_en", 32'(CMP_EN), 32'd0);
        REQ_A[0*DW +: DW] = 16'd5;
        REQ_B[0*DW +: DW] = 16'd5;
        REQ_FUN[0 +: 2]   = 2'd1;
        REQ_A[2*DW +: DW] = 16'd9;
        REQ_B[2*DW +: DW] = 16'd1;
        REQ_FUN[4 +: 2]   = 2'd2;
        REQ_VALID = 4'b0101;
        RST = 1'b0;
        #1;
        checkOutput("t6_rst_cmp_a",     32'(CMP_A),     32'd0);
        checkOutput("t6_rst_cmp_b",     32'(CMP_B),     32'd0);
        checkOutput("t6_rst_cmp_fun",   32'(CMP_FUN),   32'd0);
        checkOutput("t6_rst_cmp_en",    32'(CMP_EN),    32'd0);
        checkOutput("t6_rst_rsp_valid", 32'(RSP_VALID), 32'd0);
        checkOutput("t6_rst_rsp_out",   32'(RSP_OUT),   32'd0);
        checkOutput("t6_rst_req_ready", 32'(REQ_READY), 32'd0);
        @(negedge CLK);
        checkOutput("t6_rst_req_ready2", 32'(REQ_READY), 32'd0);
        pushExp(2'd0, 2'd1, 1'b0);
        pushExp(2'd2, 2'd2, 1'b0);
        n0 = grant_id_q.size();
        @(posedge CLK);
        #1;
        RST = 1'b1;
        @(negedge CLK);
        checkOutput("t6_first_grant", 32'(REQ_READY), 32'b0001);
        @(posedge CLK);
        #1;
        REQ_VALID[0] = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (grant_id_q.size() > n0 + 1) break;
        end
        checkOutput("t6_grant_count", 32'(grant_id_q.size() - n0), 32'd2);
        if (grant_id_q.size() > n0 + 1)
            checkOutput("t6_second_grant", 32'(grant_id_q[n0+1]), 32'd2);
        @(posedge CLK);
        #1;
        REQ_VALID[2] = 1'b0;
        waitDrain("t6_drain");

        repeat (3) @(negedge CLK);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
